// File: rtl/alu_operand_stage.sv
// Operand stage in front of the 64-bit ALU: integer register file with X31 reading
// as zero, operand select, and a one-deep valid/ready output slot.
// Optional feature macro WB_BYPASS_EN: forwards same-cycle write-back data into the capture.
module alu_operand_stage #(
   parameter int WIDTH = 64,
   parameter int NREG  = 32,
   parameter int AW    = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [AW-1:0]    in_rn,
   input  logic [AW-1:0]    in_rm,
   input  logic [AW-1:0]    in_rd,
   input  logic [WIDTH-1:0] in_imm,
   input  logic             in_alu_src,
   input  logic [3:0]       in_alu_ctl,
   input  logic             in_reg_write,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [3:0]       out_c,
   output logic [AW-1:0]    out_rd,
   output logic             out_reg_write,
   input  logic             wb_en,
   input  logic [AW-1:0]    wb_addr,
   input  logic [WIDTH-1:0] wb_data
);

   localparam logic [AW-1:0] ZR_IDX = AW'(NREG - 1);

   logic [WIDTH-1:0] regs [NREG];
   logic [WIDTH-1:0] rd_a;
   logic [WIDTH-1:0] rd_b;
   logic             capture;
   logic             wb_live;

   function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] idx);
      logic [WIDTH-1:0] val;
      val = regs[idx];
`ifdef WB_BYPASS_EN
      // Write-first: a write-back landing this edge is visible to the capture.
      if (wb_live && wb_addr == idx)
         val = wb_data;
`endif
      if (idx == ZR_IDX)
         val = '0;
      return val;
   endfunction

   assign wb_live  = wb_en && (wb_addr != ZR_IDX);
   assign in_ready = !out_valid || out_ready;
   assign capture  = in_valid && in_ready && !flush;

   always_comb begin
      rd_a = read_port(in_rn);
      rd_b = in_alu_src ? in_imm : read_port(in_rm);
   end

   // NOTE: the register file is cleared by reset like any other state here, so it
   // is written from the same clocked block and uses non-blocking assignments.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
         out_valid     <= 1'b0;
         out_a         <= '0;
         out_b         <= '0;
         out_c         <= 4'b0000;
         out_rd        <= '0;
         out_reg_write <= 1'b0;
      end else begin
         if (wb_live)
            regs[wb_addr] <= wb_data;

         if (flush) begin
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
         end else if (capture) begin
            out_valid     <= 1'b1;
            out_a         <= rd_a;
            out_b         <= rd_b;
            out_c         <= in_alu_ctl;
            out_rd        <= in_rd;
            out_reg_write <= in_reg_write;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus a randomized
// run, all compared against a behavioural model of the stage.
module tb_alu_operand_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rn, in_rm, in_rd;
   logic [63:0] in_imm;
   logic        in_alu_src;
   logic [3:0]  in_alu_ctl;
   logic        in_reg_write;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_a, out_b;
   logic [3:0]  out_c;
   logic [4:0]  out_rd;
   logic        out_reg_write;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [63:0] wb_data;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   alu_operand_stage dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd), .in_imm(in_imm),
      .in_alu_src(in_alu_src), .in_alu_ctl(in_alu_ctl), .in_reg_write(in_reg_write),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_rd(out_rd),
      .out_reg_write(out_reg_write),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
   );

   // Reference model: architectural registers plus the contents of the output slot.
   logic [63:0] m_regs [32];
   logic        m_valid = 1'b0;
   logic        m_rw    = 1'b0;
   logic [63:0] m_a, m_b;
   logic [3:0]  m_c;
   logic [4:0]  m_rd;

   function automatic logic [63:0] m_read(input logic [4:0] idx);
      if (idx == 5'd31) return 64'd0;
`ifdef WB_BYPASS_EN
      if (wb_en && wb_addr == idx) return wb_data;
`endif
      return m_regs[idx];
   endfunction

   // Payload is only meaningful while the slot is live, so it is masked otherwise.
   function automatic logic [138:0] exp_vec();
      return {m_valid, m_rw, m_valid ? {m_a, m_b, m_c, m_rd} : 137'd0};
   endfunction

   function automatic logic [138:0] obs_vec();
      return {out_valid, out_reg_write, m_valid ? {out_a, out_b, out_c, out_rd} : 137'd0};
   endfunction

   task automatic idle_inputs();
      in_valid = 0; in_rn = 0; in_rm = 0; in_rd = 0; in_imm = 0; in_alu_src = 0;
      in_alu_ctl = 0; in_reg_write = 0; flush = 0; out_ready = 1;
      wb_en = 0; wb_addr = 0; wb_data = 0;
   endtask

   task automatic issue(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                        input logic src, input logic [63:0] imm, input logic [3:0] ctl);
      in_valid = 1; in_rn = rn; in_rm = rm; in_rd = rd; in_alu_src = src;
      in_imm = imm; in_alu_ctl = ctl; in_reg_write = 1;
   endtask

   // Advances one clock: checks in_ready, updates the model from the inputs that
   // are present at the edge, and returns 1 time unit after the edge.
   task automatic step();
      logic exp_ready, cap;
      logic [63:0] ra, rb;
      #1;
      exp_ready = !m_valid || out_ready;
      if (!reset) begin
         checks++;
         if (in_ready !== exp_ready) begin
            failures++;
            $display("FAIL in_ready: got %b expected %b at %0t", in_ready, exp_ready, $time);
         end
      end
      if (reset) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
         m_valid = 0; m_rw = 0; m_a = 0; m_b = 0; m_c = 0; m_rd = 0;
      end else begin
         cap = in_valid && exp_ready && !flush;
         ra  = m_read(in_rn);
         rb  = in_alu_src ? in_imm : m_read(in_rm);
         if (flush) begin
            m_valid = 0; m_rw = 0;
         end else if (cap) begin
            m_valid = 1; m_a = ra; m_b = rb; m_c = in_alu_ctl; m_rd = in_rd; m_rw = in_reg_write;
         end else if (out_ready) begin
            m_valid = 0;
         end
         if (wb_en && wb_addr != 5'd31) m_regs[wb_addr] = wb_data;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      in_valid = 1; in_rn = 5'd3;
      reset = 1;
      step();
      step();
      checks++;
      if ({out_valid, out_reg_write, out_a, out_b, out_c, out_rd} !== 139'd0) begin
         failures++;
         $display("FAIL reset_state: got v=%b rw=%b a=%h b=%h c=%h rd=%h expected all zero",
                  out_valid, out_reg_write, out_a, out_b, out_c, out_rd);
      end
      reset = 0;
      in_valid = 0;
      for (int i = 0; i < 32; i++) begin
         issue(5'(i), 5'(i), 5'(i), 1'b0, 64'd0, 4'd0);
         step();
         checks++;
         if (out_valid !== 1'b1 || out_a !== 64'd0 || out_b !== 64'd0) begin
            failures++;
            $display("FAIL reset_regs: R[%0d] got v=%b a=%h b=%h expected v=1 a=0 b=0",
                     i, out_valid, out_a, out_b);
         end
      end
      idle_inputs();
      step();
   endtask

   task automatic test_basic();
      idle_inputs();
      wb_en = 1; wb_addr = 5'd1; wb_data = 64'd27;
      step();
      wb_addr = 5'd2; wb_data = 64'd43;
      step();
      wb_en = 0;
      issue(5'd1, 5'd2, 5'd7, 1'b0, 64'd999, 4'b0010);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_a !== 64'd27 || out_b !== 64'd43 || out_c !== 4'b0010 ||
          out_rd !== 5'd7 || out_reg_write !== 1'b1) begin
         failures++;
         $display("FAIL basic_issue: got v=%b a=%0d b=%0d c=%b rd=%0d expected v=1 a=27 b=43 c=0010 rd=7",
                  out_valid, out_a, out_b, out_c, out_rd);
      end
      in_valid = 0;
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL basic_drain: got out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_zero_reg();
      idle_inputs();
      wb_en = 1; wb_addr = 5'd31; wb_data = 64'd5;
      step();
      wb_en = 0;
      issue(5'd31, 5'd31, 5'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0110);
      step();
      checks++;
      if (out_a !== 64'd0 || out_b !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         failures++;
         $display("FAIL zero_reg: got a=%h b=%h expected a=0 b=ffffffffffffffff", out_a, out_b);
      end
      issue(5'd4, 5'd31, 5'd4, 1'b0, 64'd0, 4'b0);
      step();
      checks++;
      if (out_b !== 64'd0) begin
         failures++;
         $display("FAIL zero_reg_rm: got b=%h expected 0", out_b);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_stall();
      idle_inputs();
      issue(5'd1, 5'd2, 5'd9, 1'b0, 64'd0, 4'b1010);
      step();
      issue(5'd2, 5'd1, 5'd10, 1'b1, 64'h1234, 4'b0101);
      out_ready = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_a !== 64'd27 || out_b !== 64'd43 ||
             out_c !== 4'b1010 || out_rd !== 5'd9) begin
            failures++;
            $display("FAIL stall_hold[%0d]: got rdy=%b v=%b a=%0d b=%0d c=%b rd=%0d expected rdy=0 v=1 a=27 b=43 c=1010 rd=9",
                     k, in_ready, out_valid, out_a, out_b, out_c, out_rd);
         end
      end
      out_ready = 1;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_a !== 64'd43 || out_b !== 64'h1234 || out_c !== 4'b0101 ||
          out_rd !== 5'd10) begin
         failures++;
         $display("FAIL stall_release: got v=%b a=%0d b=%h c=%b rd=%0d expected v=1 a=43 b=1234 c=0101 rd=10",
                  out_valid, out_a, out_b, out_c, out_rd);
      end
   endtask

   task automatic test_flush();
      out_ready = 0;
      issue(5'd1, 5'd1, 5'd11, 1'b0, 64'd0, 4'b0001);
      step();
      flush = 1;
      step();
      checks++;
      if (out_valid !== 1'b0 || out_reg_write !== 1'b0) begin
         failures++;
         $display("FAIL flush_stall: got v=%b rw=%b expected v=0 rw=0", out_valid, out_reg_write);
      end
      out_ready = 1;
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_drop: got v=%b expected 0", out_valid);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_wb_same_cycle();
      logic [63:0] exp_a;
`ifdef WB_BYPASS_EN
      exp_a = 64'd10;
`else
      exp_a = 64'd5;
`endif
      idle_inputs();
      wb_en = 1; wb_addr = 5'd3; wb_data = 64'd5;
      step();
      wb_data = 64'd10;
      issue(5'd3, 5'd3, 5'd3, 1'b0, 64'd0, 4'b0011);
      step();
      checks++;
      if (out_a !== exp_a || out_b !== exp_a) begin
         failures++;
         $display("FAIL wb_same_cycle: got a=%0d b=%0d expected %0d", out_a, out_b, exp_a);
      end
      wb_en = 0;
      step();
      checks++;
      if (out_a !== 64'd10) begin
         failures++;
         $display("FAIL wb_after: got a=%0d expected 10", out_a);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         in_valid     = $urandom_range(0, 3) != 0;
         in_rn        = 5'($urandom);
         in_rm        = 5'($urandom);
         in_rd        = 5'($urandom);
         in_imm       = {$urandom, $urandom};
         in_alu_src   = 1'($urandom);
         in_alu_ctl   = 4'($urandom);
         in_reg_write = 1'($urandom);
         flush        = $urandom_range(0, 15) == 0;
         out_ready    = $urandom_range(0, 2) != 0;
         wb_en        = 1'($urandom);
         wb_addr      = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
         wb_data      = {$urandom, $urandom};
         step();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL random[%0d]: got %h expected %h", n, obs_vec(), exp_vec());
         end
      end
      idle_inputs();
      step();
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      test_reset();
      test_basic();
      test_zero_reg();
      test_stall();
      test_flush();
      test_wb_same_cycle();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
